// File: rtl/flex_sr_rx_framer.sv
// Serial receive framer: recovers start/data/stop framed words from an idle-high line
// and presents them on a holding register with ready, framing-error and overrun flags.
module flex_sr_rx_framer #(
  parameter int NUM_BITS     = 8,
  parameter int SHIFT_MSB    = 1,
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_serial_in,
  input  logic                i_data_read,
  output logic [NUM_BITS-1:0] o_rx_data,
  output logic                o_data_ready,
  output logic                o_framing_error,
  output logic                o_overrun_error,
  output logic                o_rx_busy,
  output logic [2:0]          o_state
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START_CHK = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  // Handshake: o_data_ready stays high from a good load until an i_data_read pulse
  // is seen at a clock edge; a load on that same edge wins and keeps it high.

  logic                r_sync1;
  logic                r_sync2;
  logic                r_s_prev;
  state_t              r_state;
  logic [TW-1:0]       r_timer;
  logic [CW-1:0]       r_cnt;
  logic [NUM_BITS-1:0] r_shift;
  logic [NUM_BITS-1:0] r_rx_data;
  logic                r_data_ready;
  logic                r_framing_error;
  logic                r_overrun_error;
  logic                r_rx_busy;

  state_t              w_state_nx;
  logic [TW-1:0]       w_timer_nx;
  logic [CW-1:0]       w_cnt_nx;
  logic [NUM_BITS-1:0] w_shift_nx;
  logic                w_busy_nx;
  logic                w_good_load;
  logic                w_bad_stop;
  logic                w_fall;
  logic                w_tick;
  logic [NUM_BITS-1:0] w_shifted;

  assign w_fall = ~r_sync2 & r_s_prev;
  assign w_tick = (r_timer == '0);

  always_comb begin
    w_shifted = r_shift;
    if (SHIFT_MSB != 0) begin
      w_shifted = {r_shift[NUM_BITS-2:0], r_sync2};
    end else begin
      w_shifted = {r_sync2, r_shift[NUM_BITS-1:1]};
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_timer_nx  = r_timer;
    w_cnt_nx    = r_cnt;
    w_shift_nx  = r_shift;
    w_busy_nx   = r_rx_busy;
    w_good_load = 1'b0;
    w_bad_stop  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_nx = S_START_CHK;
          w_timer_nx = TW'(H - 1);
          w_busy_nx  = 1'b1;
        end
      end
      S_START_CHK: begin
        if (w_tick) begin
          if (r_sync2) begin
            w_state_nx = S_IDLE;
            w_busy_nx  = 1'b0;
          end else begin
            w_state_nx = S_DATA;
            w_timer_nx = TW'(CLKS_PER_BIT - 1);
            w_cnt_nx   = '0;
          end
        end else begin
          w_timer_nx = r_timer - TW'(1);
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_nx = w_shifted;
          w_timer_nx = TW'(CLKS_PER_BIT - 1);
          if (r_cnt == CW'(NUM_BITS - 1)) begin
            w_state_nx = S_STOP;
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end else begin
          w_timer_nx = r_timer - TW'(1);
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_sync2) begin
            w_good_load = 1'b1;
            w_state_nx  = S_IDLE;
            w_busy_nx   = 1'b0;
          end else begin
            w_bad_stop = 1'b1;
            w_state_nx = S_WAIT_IDLE;
          end
        end else begin
          w_timer_nx = r_timer - TW'(1);
        end
      end
      S_WAIT_IDLE: begin
        // A broken frame leaves the line low; hold off new starts until it idles.
        if (r_sync2) begin
          w_state_nx = S_IDLE;
          w_busy_nx  = 1'b0;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1         <= 1'b1;
      r_sync2         <= 1'b1;
      r_s_prev        <= 1'b1;
      r_state         <= S_IDLE;
      r_timer         <= '0;
      r_cnt           <= '0;
      r_shift         <= '0;
      r_rx_data       <= '1;
      r_data_ready    <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun_error <= 1'b0;
      r_rx_busy       <= 1'b0;
    end else begin
      r_sync1   <= i_serial_in;
      r_sync2   <= r_sync1;
      r_s_prev  <= r_sync2;
      r_state   <= w_state_nx;
      r_timer   <= w_timer_nx;
      r_cnt     <= w_cnt_nx;
      r_shift   <= w_shift_nx;
      r_rx_busy <= w_busy_nx;
      if (w_good_load) begin
        r_rx_data       <= r_shift;
        r_data_ready    <= 1'b1;
        r_framing_error <= 1'b0;
        if (r_data_ready && !i_data_read) begin
          r_overrun_error <= 1'b1;
        end else if (i_data_read) begin
          r_overrun_error <= 1'b0;
        end
      end else begin
        if (w_bad_stop) begin
          r_framing_error <= 1'b1;
        end
        if (i_data_read) begin
          r_data_ready    <= 1'b0;
          r_overrun_error <= 1'b0;
        end
      end
    end
  end

  assign o_rx_data       = r_rx_data;
  assign o_data_ready    = r_data_ready;
  assign o_framing_error = r_framing_error;
  assign o_overrun_error = r_overrun_error;
  assign o_rx_busy       = r_rx_busy;
  assign o_state         = r_state;

endmodule
